wb_checker: RTL and testbench
=============================

WB_CHECKER -- requirements
Module: wb_checker

Interface
REQ-001 Parameter CYCLE_LIMIT, default 100: number of RUN cycles to capture before checking.
REQ-002 Parameter NUM_CHECKS, default 8: number of expected-value entries, 1..16.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a capture run.
REQ-006 rf_write_enable  input  1  writeback-stage register write strobe.
REQ-007 rf_write_ctrl  input  5  writeback destination register number.
REQ-008 rf_write_data  input  32  writeback data.
REQ-009 exp_we  input  1  write strobe for an expected-value table entry.
REQ-010 exp_idx  input  4  table entry index.
REQ-011 exp_reg  input  5  register number to check for that entry.
REQ-012 exp_val  input  32  expected value for that entry.
REQ-013 busy  output  1  high in RUN or CHECK.
REQ-014 done  output  1  high in DONE.
REQ-015 pass  output  1  high in DONE when error_count is 0.
REQ-016 error_count  output  8  mismatches found, saturating at 255.
REQ-017 first_err_reg  output  5  register number of the first mismatch; 0 if none.

Function
REQ-018 FSM states: IDLE, RUN, CHECK, DONE; IDLE -> RUN on start; RUN -> CHECK when the cycle counter reaches CYCLE_LIMIT-1; CHECK -> DONE after entry NUM_CHECKS-1 is compared; DONE -> RUN on start.
REQ-019 Shadow register file: 32 x 32 bits; in RUN, rf_write_enable=1 writes rf_write_data to entry rf_write_ctrl on the same edge.
REQ-020 Writes to register 0 are discarded; shadow entry 0 always reads 0.
REQ-021 Writeback strobes outside RUN do not modify the shadow file.
REQ-022 The cycle counter is 32-bit, is cleared on entering RUN, and increments once per RUN cycle; RUN lasts exactly CYCLE_LIMIT cycles.
REQ-023 A writeback on the last RUN cycle is captured before checking begins.
REQ-024 CHECK compares one entry per cycle, indices 0..NUM_CHECKS-1 ascending, using a 4-bit index: shadow[exp_reg[i]] !== exp_val[i] increments error_count.
REQ-025 On the first mismatch of a run, first_err_reg captures exp_reg[i]; later mismatches do not change it.
REQ-026 CHECK latency is exactly NUM_CHECKS cycles; done asserts on the cycle after the last compare.
REQ-027 The expected table is writable only in IDLE or DONE; exp_we in RUN or CHECK is ignored.
REQ-028 start in RUN or CHECK is ignored.
REQ-029 start in DONE clears error_count, first_err_reg, the cycle counter, and the shadow file, then enters RUN.
REQ-030 error_count saturates at 255 and does not wrap.

Reset
REQ-031 Reset forces: state IDLE, busy=0, done=0, pass=0, error_count=0, first_err_reg=0, cycle counter=0, and all shadow entries=0.
REQ-032 Reset clears all expected-table entries to exp_reg=0 and exp_val=0.
REQ-033 Reset takes priority over start, exp_we, and writeback strobes in the same cycle; asserting reset mid-RUN or mid-CHECK aborts the run with no done pulse.

Structure
REQ-034 A shared package holds the FSM state encoding, the register-count constant (32), the data-width constant (32), and the error-count width (8).
REQ-035 The shadow register file is a sub-module, wb_shadow_rf: one synchronous write port with r0 write-suppression, one combinational read port, and a synchronous clear input.

Verification
REQ-036 Load entry0=(r1,5) and entry1=(r2,7); start; writebacks r1<=5 and r2<=7; CYCLE_LIMIT=10, NUM_CHECKS=2 -> done on cycle 13 after start, pass=1, error_count=0.
REQ-037 Expected (r3,9); writeback r3<=8 -> error_count=1, first_err_reg=3, pass=0.
REQ-038 Writeback r0<=0xFFFF_FFFF; expected (r0,0) -> pass=1.
REQ-039 Writeback r4<=1 one cycle before start and r4<=2 on the last RUN cycle; expected (r4,2) -> pass=1.
REQ-040 Assert reset on RUN cycle 5 -> next cycle busy=0, state IDLE, no done; a subsequent start runs a full CYCLE_LIMIT cycles.
REQ-041 From DONE with error_count=3, issue start with all entries matching -> second run ends with error_count=0 and first_err_reg=0.

Source files
------------

// File: rtl/wb_checker_pkg.sv
// Shared constants, FSM encoding and helpers for the writeback checker.
package wb_checker_pkg;

    // Architectural register file geometry
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;

    // Mismatch counter width and expected-table index width
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned TBL_SZ   = 16;

    // Checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_checker_if.sv
// Bundle of writeback, expected-table and status signals for wb_checker.
interface wb_checker_if;
    import wb_checker_pkg::*;

    // Run control
    logic              start;

    // Writeback-stage observation
    logic              rf_write_enable;
    logic [REG_AW-1:0] rf_write_ctrl;
    logic [DATA_W-1:0] rf_write_data;

    // Expected-value table load
    logic              exp_we;
    logic [IDX_W-1:0]  exp_idx;
    logic [REG_AW-1:0] exp_reg;
    logic [DATA_W-1:0] exp_val;

    // Status
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  error_count;
    logic [REG_AW-1:0] first_err_reg;

    // Stimulus side: drives the core and watches its status
    modport master (
        output start, rf_write_enable, rf_write_ctrl, rf_write_data,
        output exp_we, exp_idx, exp_reg, exp_val,
        input  busy, done, pass, error_count, first_err_reg
    );

    // Checker side
    modport slave (
        input  start, rf_write_enable, rf_write_ctrl, rf_write_data,
        input  exp_we, exp_idx, exp_reg, exp_val,
        output busy, done, pass, error_count, first_err_reg
    );

endinterface

// File: rtl/wb_shadow_rf.sv
// Shadow copy of the architectural register file. One synchronous write
// port (r0 writes dropped), one combinational read port, synchronous clear.
module wb_shadow_rf
    import wb_checker_pkg::*;
(
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Clear wins over write; r0 is never written so it stays at zero
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // r0 is hard-wired to zero on the read side as well
    assign rdata_o = (raddr_i == '0) ? '0 : mem_q[raddr_i];

endmodule

// File: rtl/wb_checker.sv
// Writeback checker: captures register writebacks for CYCLE_LIMIT cycles,
// then compares NUM_CHECKS (register, value) expectations against the
// captured state, one per cycle, and reports the mismatch summary.
module wb_checker
    import wb_checker_pkg::*;
#(
    parameter int unsigned CYCLE_LIMIT = 100,
    parameter int unsigned NUM_CHECKS  = 8
) (
    input  logic         clock,
    input  logic         reset,
    wb_checker_if.slave  bus
);

    localparam logic [31:0]      LAST_CYC = 32'(CYCLE_LIMIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W:0]   NCHK     = (IDX_W + 1)'(NUM_CHECKS);

    // Control state
    state_t            state_q;
    logic [31:0]       cnt_q;
    logic [IDX_W-1:0]  chk_q;
    logic [ERR_W-1:0]  err_q,  err_d;
    logic [REG_AW-1:0] ferr_q, ferr_d;
    logic              busy_q, done_q, pass_q;

    // Expected-value table; always 16 deep so the 4-bit index never overruns,
    // only the first NUM_CHECKS entries are writable or compared
    logic [REG_AW-1:0] exp_reg_q [TBL_SZ];
    logic [DATA_W-1:0] exp_val_q [TBL_SZ];

    logic              tbl_open;
    logic              rf_clr;
    logic              rf_we;
    logic [DATA_W-1:0] rd_data;
    logic              mismatch;

    // Table loads and new runs are only accepted while not running
    assign tbl_open = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // Restart from DONE wipes the previous run's captured state
    assign rf_clr = reset || (bus.start && (state_q == ST_DONE));
    assign rf_we  = (state_q == ST_RUN) && bus.rf_write_enable;

    wb_shadow_rf u_shadow (
        .clk_i   (clock),
        .clr_i   (rf_clr),
        .we_i    (rf_we),
        .waddr_i (bus.rf_write_ctrl),
        .wdata_i (bus.rf_write_data),
        .raddr_i (exp_reg_q[chk_q]),
        .rdata_o (rd_data)
    );

    assign mismatch = (rd_data != exp_val_q[chk_q]);

    // Mismatch bookkeeping for the entry under comparison this cycle
    always_comb begin
        err_d  = err_q;
        ferr_d = ferr_q;
        if ((state_q == ST_CHECK) && mismatch) begin
            err_d = sat_inc(err_q);
            if (err_q == '0) begin
                ferr_d = exp_reg_q[chk_q];
            end
        end
    end

    // Expected table: cleared by reset, loadable only in IDLE/DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TBL_SZ; i++) begin
                exp_reg_q[i] <= '0;
                exp_val_q[i] <= '0;
            end
        end else if (bus.exp_we && tbl_open && ({1'b0, bus.exp_idx} < NCHK)) begin
            exp_reg_q[bus.exp_idx] <= bus.exp_reg;
            exp_val_q[bus.exp_idx] <= bus.exp_val;
        end
    end

    // Run/check sequencer with registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        chk_q   <= '0;
                        err_q   <= '0;
                        ferr_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (cnt_q == LAST_CYC) begin
                        state_q <= ST_CHECK;
                        chk_q   <= '0;
                    end
                end
                ST_CHECK: begin
                    err_q  <= err_d;
                    ferr_q <= ferr_d;
                    if (chk_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        chk_q <= chk_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.error_count   = err_q;
    assign bus.first_err_reg = ferr_q;

endmodule

// File: tb/tb_wb_checker.sv
// Directed bench for wb_checker. Two instances share one stimulus stream:
// dut1 with NUM_CHECKS=2 and dut2 with NUM_CHECKS=4, both CYCLE_LIMIT=10.
// Expected run results are queued per instance and popped by monitors on
// the rising edge of done.
module tb_wb_checker;

    localparam int CL   = 10;
    localparam int N1   = 2;
    localparam int N2   = 4;
    // start cycle -> CL RUN cycles -> N CHECK cycles -> DONE visible
    localparam int LAT1 = CL + N1 + 1;
    localparam int LAT2 = CL + N2 + 1;

    typedef struct {
        int         lat;
        logic [7:0] err;
        logic [4:0] ferr;
        logic       pass;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   start_cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic done1_prev = 1'b0;
    logic done2_prev = 1'b0;
    exp_t sb1[$];
    exp_t sb2[$];

    wb_checker_if bus1 ();
    wb_checker_if bus2 ();

    assign bus2.start           = bus1.start;
    assign bus2.rf_write_enable = bus1.rf_write_enable;
    assign bus2.rf_write_ctrl   = bus1.rf_write_ctrl;
    assign bus2.rf_write_data   = bus1.rf_write_data;
    assign bus2.exp_we          = bus1.exp_we;
    assign bus2.exp_idx         = bus1.exp_idx;
    assign bus2.exp_reg         = bus1.exp_reg;
    assign bus2.exp_val         = bus1.exp_val;

    wb_checker #(.CYCLE_LIMIT(CL), .NUM_CHECKS(N1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    wb_checker #(.CYCLE_LIMIT(CL), .NUM_CHECKS(N2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [7:0] err,
                         input logic [4:0] ferr, input logic pass, input logic busy);
        chk({tag, " latency"}, 32'(cyc - start_cyc), 32'(e.lat));
        chk({tag, " error_count"}, 32'(err), 32'(e.err));
        chk({tag, " first_err_reg"}, 32'(ferr), 32'(e.ferr));
        chk({tag, " pass"}, 32'(pass), 32'(e.pass));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    // Monitor for dut1
    always @(negedge clock) begin
        if (bus1.done && !done1_prev) begin
            if (sb1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut1 unexpected done: got done=1, want done=0 (t=%0t)", $time);
            end else begin
                score("dut1", sb1.pop_front(), bus1.error_count, bus1.first_err_reg,
                      bus1.pass, bus1.busy);
            end
        end
        done1_prev <= bus1.done;
    end

    // Monitor for dut2
    always @(negedge clock) begin
        if (bus2.done && !done2_prev) begin
            if (sb2.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut2 unexpected done: got done=1, want done=0 (t=%0t)", $time);
            end else begin
                score("dut2", sb2.pop_front(), bus2.error_count, bus2.first_err_reg,
                      bus2.pass, bus2.busy);
            end
        end
        done2_prev <= bus2.done;
    end

    // All stimulus tasks are entered and left at a falling edge
    task automatic load(input logic [3:0] idx, input logic [4:0] r, input logic [31:0] v);
        bus1.exp_we  = 1'b1;
        bus1.exp_idx = idx;
        bus1.exp_reg = r;
        bus1.exp_val = v;
        @(negedge clock);
        bus1.exp_we  = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        bus1.rf_write_enable = 1'b1;
        bus1.rf_write_ctrl   = r;
        bus1.rf_write_data   = v;
        @(negedge clock);
        bus1.rf_write_enable = 1'b0;
    endtask

    task automatic pulse_start();
        bus1.start = 1'b1;
        start_cyc  = cyc;
        @(negedge clock);
        bus1.start = 1'b0;
    endtask

    task automatic expect_run(input logic [7:0] e1, input logic [4:0] f1,
                              input logic [7:0] e2, input logic [4:0] f2);
        exp_t e;
        e.lat = LAT1; e.err = e1; e.ferr = f1; e.pass = (e1 == 8'd0);
        sb1.push_back(e);
        e.lat = LAT2; e.err = e2; e.ferr = f2; e.pass = (e2 == 8'd0);
        sb2.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb1.size() != 0 || sb2.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb1.size() != 0 || sb2.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL run timeout: got %0d/%0d results pending, want 0", sb1.size(), sb2.size());
            sb1.delete();
            sb2.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        bus1.start           = 1'b0;
        bus1.rf_write_enable = 1'b0;
        bus1.rf_write_ctrl   = '0;
        bus1.rf_write_data   = '0;
        bus1.exp_we          = 1'b0;
        bus1.exp_idx         = '0;
        bus1.exp_reg         = '0;
        bus1.exp_val         = '0;

        // Reset held while strobes are active: reset must win
        @(negedge clock);
        bus1.start = 1'b1;
        bus1.exp_we = 1'b1;
        bus1.exp_reg = 5'd7;
        bus1.exp_val = 32'd99;
        repeat (2) @(negedge clock);
        bus1.start  = 1'b0;
        bus1.exp_we = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("reset busy", 32'(bus1.busy), 32'd0);
        chk("reset done", 32'(bus1.done), 32'd0);
        chk("reset pass", 32'(bus1.pass), 32'd0);
        chk("reset error_count", 32'(bus1.error_count), 32'd0);
        chk("reset first_err_reg", 32'(bus1.first_err_reg), 32'd0);

        // Basic matching run
        load(4'd0, 5'd1, 32'd5);
        load(4'd1, 5'd2, 32'd7);
        expect_run(8'd0, 5'd0, 8'd0, 5'd0);
        pulse_start();
        chk("busy in run", 32'(bus1.busy), 32'd1);
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        wait_done();

        // Single mismatch; a start pulse mid-run must be ignored
        load(4'd0, 5'd3, 32'd9);
        load(4'd1, 5'd1, 32'd0);
        expect_run(8'd1, 5'd3, 8'd1, 5'd3);
        pulse_start();
        wb(5'd3, 32'd8);
        repeat (2) @(negedge clock);
        bus1.start = 1'b1;
        @(negedge clock);
        bus1.start = 1'b0;
        wait_done();

        // r0 writes are discarded
        load(4'd0, 5'd0, 32'd0);
        load(4'd1, 5'd5, 32'd0);
        expect_run(8'd0, 5'd0, 8'd0, 5'd0);
        pulse_start();
        wb(5'd0, 32'hFFFF_FFFF);
        wait_done();

        // Pre-run write ignored, last-RUN-cycle write captured,
        // table load and writeback during RUN/CHECK ignored
        load(4'd0, 5'd4, 32'd2);
        load(4'd1, 5'd4, 32'd2);
        expect_run(8'd0, 5'd0, 8'd0, 5'd0);
        wb(5'd4, 32'd1);
        pulse_start();
        repeat (3) @(negedge clock);
        load(4'd1, 5'd6, 32'd123);
        repeat (5) @(negedge clock);
        wb(5'd4, 32'd2);
        wb(5'd4, 32'd7);
        wait_done();

        // Reset during RUN aborts with no done pulse
        load(4'd0, 5'd1, 32'd0);
        load(4'd1, 5'd2, 32'd0);
        pulse_start();
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort busy dut1", 32'(bus1.busy), 32'd0);
        chk("abort busy dut2", 32'(bus2.busy), 32'd0);
        chk("abort done", 32'(bus1.done), 32'd0);
        repeat (20) @(negedge clock);
        chk("post-abort done", 32'(bus1.done), 32'd0);
        chk("post-abort busy", 32'(bus1.busy), 32'd0);

        // Fresh run after abort takes the full latency
        load(4'd0, 5'd1, 32'd0);
        load(4'd1, 5'd2, 32'd0);
        expect_run(8'd0, 5'd0, 8'd0, 5'd0);
        pulse_start();
        wait_done();

        // Multiple mismatches (dut2 reaches 3), then a clean rerun clears them
        load(4'd0, 5'd1, 32'd11);
        load(4'd1, 5'd2, 32'd22);
        load(4'd2, 5'd3, 32'd33);
        load(4'd3, 5'd0, 32'd0);
        expect_run(8'd2, 5'd1, 8'd3, 5'd1);
        pulse_start();
        wait_done();
        chk("dut2 error_count before rerun", 32'(bus2.error_count), 32'd3);
        load(4'd0, 5'd1, 32'd0);
        load(4'd1, 5'd2, 32'd0);
        load(4'd2, 5'd3, 32'd0);
        expect_run(8'd0, 5'd0, 8'd0, 5'd0);
        pulse_start();
        chk("rerun clears error_count", 32'(bus2.error_count), 32'd0);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
